shift_add_multiplier: RTL
=========================

SHIFT_ADD_MULTIPLIER -- requirements
Module: shift_add_multiplier

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 Port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-003 Port reset, input, 1, synchronous active-high reset, sampled on the rising clock edge.
REQ-004 Port start, input, 1, request; level-held by the requester until ready is seen.
REQ-005 Port abort, input, 1, cancels an operation in progress.
REQ-006 Port signed_mode, input, 1: 1 selects two's-complement operands, 0 selects unsigned; sampled with the operands.
REQ-007 Port multiplicand, input, WIDTH, operand A.
REQ-008 Port multiplier, input, WIDTH, operand B.
REQ-009 Port ready, output, 1, result valid (DONE state).
REQ-010 Port busy, output, 1, operation in progress (BUSY state).
REQ-011 Port product, output, 2*WIDTH, A*B result register.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, BUSY and DONE. ready and busy SHALL decode from the state register only (Moore).
REQ-013 In IDLE with start=1 (and abort=0), the next edge SHALL:
  - capture multiplicand, multiplier and signed_mode;
  - clear the accumulator;
  - preset the step counter to WIDTH-1;
  - enter BUSY.
REQ-014 In BUSY, each edge SHALL:
  - perform one shift-add step on multiplier bit LSB-first;
  - decrement the counter.
REQ-015 In BUSY with counter=0, the edge SHALL perform the final step, load product and enter DONE. This gives exactly WIDTH BUSY cycles; ready=1 after WIDTH+1 rising edges from the edge that sampled start.
REQ-016 In signed mode:
  - the final step, which uses the multiplier MSB, SHALL subtract the multiplicand instead of adding it;
  - the accumulator SHALL be WIDTH+1 bits wide with arithmetic right shift.
  In unsigned mode, a logical shift with carry-out SHALL be used.
REQ-017 The product SHALL be exact for all operand values, with no overflow. This includes signed (-2^(WIDTH-1))*(-2^(WIDTH-1)) and unsigned (2^WIDTH-1)^2.
REQ-018 Operand and signed_mode changes after the capture edge SHALL NOT affect the operation in progress.
REQ-019 DONE SHALL hold ready=1 and a stable product while start=1. The edge on which start=0 SHALL return the FSM to IDLE; no restart occurs from DONE.
REQ-020 product SHALL retain the last completed result through IDLE. It SHALL change only on the completing edge or on reset.
REQ-021 abort=1 in BUSY SHALL return the FSM to IDLE on the next edge with product unchanged. abort SHALL take priority over completion when counter=0.
REQ-022 abort=1 in IDLE SHALL suppress start. abort SHALL be ignored in DONE.
REQ-023 If start is still 1 after an abort, a new operation SHALL begin from IDLE on the following edge.

Reset
REQ-024 reset=1 SHALL take priority over all inputs. At the next edge it SHALL force:
  - state IDLE;
  - ready=0, busy=0;
  - product=0;
  - counter=0;
  - accumulator and operand registers to 0.
REQ-025 reset asserted mid-operation (BUSY or DONE) SHALL discard the operation. After reset is released, start SHALL be required again.

Structure
REQ-026 Package multiplier_pkg SHALL hold:
  - the state enum typedef (IDLE, BUSY, DONE);
  - a helper constant for the counter width, $clog2(WIDTH).
REQ-027 The step counter SHALL be a sub-module down_counter, with parameter WIDTH_BITS and ports clock, reset, preset, decrement, preset_value, is_zero.
REQ-028 The FSM, accumulator and operand registers SHALL reside in shift_add_multiplier; no other sub-modules.

Verification
REQ-029 WIDTH=8, unsigned, 13*11, start held -> busy for 8 cycles; ready=1 after the 9th edge; product=0x008F.
REQ-030 WIDTH=8, signed, -3*5 -> product=0xFFF1. Then signed -128*-128 -> product=0x4000. Then unsigned 255*255 -> product=0xFE01.
REQ-031 start held 5 cycles in DONE, then dropped -> ready stays 1 with product stable; IDLE one edge after start=0; no second operation.
REQ-032 abort at the 4th BUSY cycle with start still 1 -> IDLE next edge with product=previous result; a new operation starts the following edge and completes normally.
REQ-033 reset at the 5th BUSY cycle -> next edge: ready=0, busy=0, product=0; with start=1 held, a new operation begins only after reset=0.
REQ-034 WIDTH=16, randomised signed and unsigned operands (1000 cases), operands toggled during BUSY -> every product matches the reference model of the captured operands; latency is 17 edges.

Source files
------------

// File: rtl/multiplier_pkg.sv
// Shared types and sizing helpers for the shift-add multiplier.
package multiplier_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // Bits needed to hold the step count WIDTH-1; never narrower than one bit.
  function automatic int counter_bits(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

  localparam int COUNTER_BITS = counter_bits(DEFAULT_WIDTH);

endpackage

// File: rtl/down_counter.sv
// Loadable down counter tracking the remaining shift-add steps.
module down_counter #(
  parameter int WIDTH_BITS = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  preset,
  input  logic                  decrement,
  input  logic [WIDTH_BITS-1:0] preset_value,
  output logic                  is_zero
);

  logic [WIDTH_BITS-1:0] count;

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (preset) begin
      count <= preset_value;
    end else if (decrement) begin
      count <= count - WIDTH_BITS'(1);
    end
  end

  assign is_zero = (count == '0);

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential shift-add multiplier: one multiplier bit per cycle, LSB first,
// signed (final-step subtract) or unsigned operands.
module shift_add_multiplier
  import multiplier_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 ready,
  output logic                 busy,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = counter_bits(WIDTH);

  state_t state, state_next;
  logic   capture, step, finish, cnt_zero;

  logic             signed_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mreg_q;
  logic [WIDTH:0]   acc_q;

  logic                   final_sub;
  logic signed [WIDTH+1:0] mc_ext, acc_ext, addend, sum;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          capture    = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        // abort wins even on the completing cycle
        if (abort) begin
          state_next = IDLE;
        end else begin
          step = 1'b1;
          if (cnt_zero) begin
            finish     = 1'b1;
            state_next = DONE;
          end
        end
      end
      DONE: begin
        if (!start) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign ready = (state == DONE);
  assign busy  = (state == BUSY);

  down_counter #(
    .WIDTH_BITS (CW)
  ) u_counter (
    .clock        (clock),
    .reset        (reset),
    .preset       (capture),
    .decrement    (step && !cnt_zero),
    .preset_value (CW'(WIDTH - 1)),
    .is_zero      (cnt_zero)
  );

  // Two guard bits keep the add/subtract exact before the right shift
  // drops back to the WIDTH+1 accumulator.
  always_comb begin
    final_sub = signed_q & cnt_zero;
    mc_ext    = signed_q ? $signed({{2{mcand_q[WIDTH-1]}}, mcand_q})
                         : $signed({2'b00, mcand_q});
    acc_ext   = $signed({signed_q & acc_q[WIDTH], acc_q});
    addend    = '0;
    if (mreg_q[0]) addend = final_sub ? -mc_ext : mc_ext;
    sum       = acc_ext + addend;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      signed_q <= 1'b0;
      mcand_q  <= '0;
      mreg_q   <= '0;
      acc_q    <= '0;
      product  <= '0;
    end else if (capture) begin
      signed_q <= signed_mode;
      mcand_q  <= multiplicand;
      mreg_q   <= multiplier;
      acc_q    <= '0;
    end else if (step) begin
      acc_q  <= sum[WIDTH+1:1];
      mreg_q <= {sum[0], mreg_q[WIDTH-1:1]};
      if (finish) product <= {sum[WIDTH:0], mreg_q[WIDTH-1:1]};
    end
  end

endmodule
